// File: rtl/command_executor.sv
// Executes decoded command frames as single-beat register-bus reads/writes
// and answers each accepted frame with a status byte, plus the read word on a successful read.
module command_executor #(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter logic [7:0]  CMD_READ       = 8'h01,
    parameter logic [7:0]  CMD_WRITE      = 8'h02,
    parameter logic [7:0]  CMD_PING       = 8'h03
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        i_valid,
    input  logic [7:0]  i_command,
    input  logic [14:0] i_address,
    input  logic [31:0] i_data,
    input  logic [1:0]  i_error,
    output logic [14:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic        o_bus_we,
    output logic        o_bus_re,
    input  logic [31:0] i_bus_rdata,
    input  logic        i_bus_ack,
    output logic        o_tx_enable,
    output logic        o_tx_mode_select,
    output logic [7:0]  o_tx_byte,
    output logic [31:0] o_tx_word,
    input  logic        i_tx_done,
    output logic        o_busy,
    output logic [7:0]  o_drop_count
);

    localparam int unsigned     TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TLAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] ST_OK      = 8'hA0;
    localparam logic [7:0] ST_BAD     = 8'hE1;
    localparam logic [7:0] ST_UNKNOWN = 8'hE2;
    localparam logic [7:0] ST_TIMEOUT = 8'hE3;

    typedef enum logic [2:0] {
        IDLE,
        BUS,
        SEND_STAT,
        GAP,
        SEND_DATA
    } state_t;

    state_t        r_state;
    logic [14:0]   r_addr;
    logic [31:0]   r_wdata;
    logic          r_is_read;
    logic [7:0]    r_status;
    logic [31:0]   r_rdata;
    logic          r_read_ok;
    logic [TW-1:0] r_timer;
    logic [7:0]    r_drop_count;

    state_t        w_next_state;
    logic [7:0]    w_next_status;
    logic [TW-1:0] w_next_timer;
    logic          w_next_read_ok;
    logic          w_latch;
    logic          w_capture;
    logic          w_drop;

    always_comb begin
        w_next_state   = r_state;
        w_next_status  = r_status;
        w_next_timer   = '0;
        w_next_read_ok = r_read_ok;
        w_latch        = 1'b0;
        w_capture      = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (i_valid) begin
                    w_latch        = 1'b1;
                    w_next_read_ok = 1'b0;
                    // Decoder errors win over whatever the command byte says.
                    if (i_error != 2'b00) begin
                        w_next_status = ST_BAD;
                        w_next_state  = SEND_STAT;
                    end else if (i_command == CMD_READ || i_command == CMD_WRITE) begin
                        w_next_state  = BUS;
                    end else if (i_command == CMD_PING) begin
                        w_next_status = ST_OK;
                        w_next_state  = SEND_STAT;
                    end else begin
                        w_next_status = ST_UNKNOWN;
                        w_next_state  = SEND_STAT;
                    end
                end
            end
            BUS: begin
                if (i_bus_ack) begin
                    w_next_status  = ST_OK;
                    w_next_read_ok = r_is_read;
                    w_capture      = r_is_read;
                    w_next_state   = SEND_STAT;
                end else if (r_timer == TLAST) begin
                    w_next_status  = ST_TIMEOUT;
                    w_next_state   = SEND_STAT;
                end else begin
                    w_next_timer   = r_timer + 1'b1;
                end
            end
            SEND_STAT: begin
                if (i_tx_done) begin
                    w_next_state = r_read_ok ? GAP : IDLE;
                end
            end
            GAP: begin
                w_next_state = SEND_DATA;
            end
            SEND_DATA: begin
                if (i_tx_done) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // A frame arriving on the cycle the FSM returns to IDLE still sees a busy state.
    assign w_drop = i_valid && (r_state != IDLE) && (r_drop_count != 8'hFF);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_is_read    <= 1'b0;
            r_status     <= '0;
            r_rdata      <= '0;
            r_read_ok    <= 1'b0;
            r_timer      <= '0;
            r_drop_count <= '0;
        end else begin
            r_state   <= w_next_state;
            r_status  <= w_next_status;
            r_timer   <= w_next_timer;
            r_read_ok <= w_next_read_ok;
            if (w_latch) begin
                r_addr    <= i_address;
                r_wdata   <= i_data;
                r_is_read <= (i_command == CMD_READ);
            end
            if (w_capture) begin
                r_rdata <= i_bus_rdata;
            end
            if (w_drop) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    assign o_bus_addr       = r_addr;
    assign o_bus_wdata      = r_wdata;
    assign o_bus_we         = (r_state == BUS) && !r_is_read;
    assign o_bus_re         = (r_state == BUS) && r_is_read;
    assign o_tx_enable      = (r_state == SEND_STAT) || (r_state == SEND_DATA);
    assign o_tx_mode_select = (r_state == SEND_DATA);
    assign o_tx_byte        = r_status;
    assign o_tx_word        = r_rdata;
    assign o_busy           = (r_state != IDLE);
    assign o_drop_count     = r_drop_count;

endmodule

// File: tb/tb_command_executor.sv
// Self-checking bench for command_executor: directed vector table, randomized frames
// against a frame-level reference model, busy-drop saturation and mid-transaction reset.
module tb_command_executor;

    localparam int TO = 16;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        i_valid;
    logic [7:0]  i_command;
    logic [14:0] i_address;
    logic [31:0] i_data;
    logic [1:0]  i_error;
    logic [14:0] o_bus_addr;
    logic [31:0] o_bus_wdata;
    logic        o_bus_we;
    logic        o_bus_re;
    logic [31:0] i_bus_rdata;
    logic        i_bus_ack;
    logic        o_tx_enable;
    logic        o_tx_mode_select;
    logic [7:0]  o_tx_byte;
    logic [31:0] o_tx_word;
    logic        i_tx_done;
    logic        o_busy;
    logic [7:0]  o_drop_count;

    always #5 clock = ~clock;

    command_executor #(.TIMEOUT_CYCLES(TO)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .i_valid          (i_valid),
        .i_command        (i_command),
        .i_address        (i_address),
        .i_data           (i_data),
        .i_error          (i_error),
        .o_bus_addr       (o_bus_addr),
        .o_bus_wdata      (o_bus_wdata),
        .o_bus_we         (o_bus_we),
        .o_bus_re         (o_bus_re),
        .i_bus_rdata      (i_bus_rdata),
        .i_bus_ack        (i_bus_ack),
        .o_tx_enable      (o_tx_enable),
        .o_tx_mode_select (o_tx_mode_select),
        .o_tx_byte        (o_tx_byte),
        .o_tx_word        (o_tx_word),
        .i_tx_done        (i_tx_done),
        .o_busy           (o_busy),
        .o_drop_count     (o_drop_count)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int model_drops = 0;

    // Observations of one frame
    int          obs_we, obs_re, obs_badbus, obs_nresp, obs_gap, obs_drops;
    logic        obs_mode0, obs_mode1, obs_timeout;
    logic [7:0]  obs_byte;
    logic [31:0] obs_word;

    typedef struct {
        logic [1:0]  err;
        logic [7:0]  cmd;
        logic [14:0] addr;
        logic [31:0] data;
        int          ack_lat;
        logic [31:0] rdata;
        int          tx_lat;
        int          extra;
        int          exp_we;
        int          exp_re;
        int          exp_nresp;
        logic [7:0]  exp_status;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Frame-level expectation straight from the command/status rules.
    task automatic model(input logic [1:0] err, input logic [7:0] cmd, input int ack_lat,
                         output int we, output int re, output int nresp, output logic [7:0] st);
        bit ok;
        int cyc;
        we = 0; re = 0; nresp = 1;
        if (err != 2'b00) st = 8'hE1;
        else if (cmd == 8'h01 || cmd == 8'h02) begin
            ok  = (ack_lat >= 1) && (ack_lat <= TO);
            cyc = ok ? ack_lat : TO;
            if (cmd == 8'h01) re = cyc; else we = cyc;
            st = ok ? 8'hA0 : 8'hE3;
            if (ok && cmd == 8'h01) nresp = 2;
        end else if (cmd == 8'h03) st = 8'hA0;
        else st = 8'hE2;
    endtask

    // extra: bit0 = stray frame 2 cycles in, bit1 = stray frame on every tx_done, bit2 = every busy cycle
    task automatic run_frame(input logic [1:0] err, input logic [7:0] cmd, input logic [14:0] addr,
                             input logic [31:0] data, input int ack_lat, input logic [31:0] rdata,
                             input int tx_lat, input int extra);
        int  req_n, en_n, cyc;
        bit  prev_en;
        @(posedge clock); #1;
        i_valid = 1'b1; i_error = err; i_command = cmd; i_address = addr; i_data = data;
        @(posedge clock); #1;
        i_valid = 1'b0; i_error = 2'b00; i_address = 15'($urandom()); i_data = $urandom();
        obs_we = 0; obs_re = 0; obs_badbus = 0; obs_nresp = 0; obs_gap = 0; obs_drops = 0;
        obs_mode0 = 1'bx; obs_mode1 = 1'bx; obs_byte = 'x; obs_word = 'x;
        req_n = 0; en_n = 0; cyc = 0; prev_en = 1'b0;
        while (o_busy && cyc < 1000) begin
            i_bus_ack = 1'b0; i_tx_done = 1'b0; i_valid = 1'b0; i_bus_rdata = $urandom();
            if (o_bus_we || o_bus_re) begin
                req_n++;
                if (o_bus_we) obs_we++;
                if (o_bus_re) obs_re++;
                if (o_bus_addr !== addr || (o_bus_we && o_bus_wdata !== data)) obs_badbus++;
                if (req_n == ack_lat) begin
                    i_bus_ack = 1'b1; i_bus_rdata = rdata;
                end
            end
            if (o_tx_enable) begin
                if (!prev_en) begin
                    en_n = 0;
                    if (obs_nresp == 0) begin obs_mode0 = o_tx_mode_select; obs_byte = o_tx_byte; end
                    else if (obs_nresp == 1) begin obs_mode1 = o_tx_mode_select; obs_word = o_tx_word; end
                    obs_nresp++;
                end
                en_n++;
                if (en_n == tx_lat) i_tx_done = 1'b1;
            end else if (obs_nresp == 1) begin
                obs_gap++;
            end
            if ((extra[0] && cyc == 2) || (extra[1] && i_tx_done) || extra[2]) begin
                i_valid = 1'b1; i_command = 8'h03; obs_drops++;
            end
            prev_en = o_tx_enable;
            @(posedge clock); #1;
            cyc++;
        end
        i_valid = 1'b0; i_bus_ack = 1'b0; i_tx_done = 1'b0;
        obs_timeout = (cyc >= 1000);
    endtask

    task automatic verify(input string tag, input int exp_we, input int exp_re, input int exp_nresp,
                          input logic [7:0] exp_st, input logic [31:0] exp_word);
        model_drops = (model_drops + obs_drops > 255) ? 255 : model_drops + obs_drops;
        check({tag, ".finished"}, 32'(obs_timeout), 32'd0);
        check({tag, ".we_cycles"}, obs_we, exp_we);
        check({tag, ".re_cycles"}, obs_re, exp_re);
        check({tag, ".bus_stable"}, obs_badbus, 0);
        check({tag, ".responses"}, obs_nresp, exp_nresp);
        check({tag, ".status"}, 32'(obs_byte), 32'(exp_st));
        check({tag, ".mode0"}, 32'(obs_mode0), 32'd0);
        if (exp_nresp == 2) begin
            check({tag, ".word"}, obs_word, exp_word);
            check({tag, ".mode1"}, 32'(obs_mode1), 32'd1);
            check({tag, ".gap"}, obs_gap, 1);
        end
        check({tag, ".drops"}, 32'(o_drop_count), model_drops);
    endtask

    vec_t vecs[11];

    initial begin
        int we, re, nr, lat, en_hi, busy_hi;
        logic [7:0] st, cmd;
        logic [1:0] err;
        logic [31:0] rd;

        vecs[0]  = '{2'b00, 8'h02, 15'h2B10, 32'h00FF12CD, 3,  32'h0,        2, 0, 3,  0,  1, 8'hA0};
        vecs[1]  = '{2'b00, 8'h01, 15'h4D25, 32'h0,        2,  32'hDEADBEEF, 1, 0, 0,  2,  2, 8'hA0};
        vecs[2]  = '{2'b00, 8'h01, 15'h1234, 32'h0,        0,  32'h11111111, 1, 0, 0,  16, 1, 8'hE3};
        vecs[3]  = '{2'b01, 8'h02, 15'h0042, 32'hCAFE0001, 3,  32'h0,        2, 0, 0,  0,  1, 8'hE1};
        vecs[4]  = '{2'b00, 8'h7F, 15'h0043, 32'h0,        3,  32'h0,        1, 0, 0,  0,  1, 8'hE2};
        vecs[5]  = '{2'b00, 8'h03, 15'h7FFF, 32'h0,        0,  32'h0,        3, 0, 0,  0,  1, 8'hA0};
        vecs[6]  = '{2'b00, 8'h01, 15'h0001, 32'h0,        1,  32'h0BADF00D, 2, 0, 0,  1,  2, 8'hA0};
        vecs[7]  = '{2'b00, 8'h02, 15'h3000, 32'h89ABCDEF, 16, 32'h0,        1, 0, 16, 0,  1, 8'hA0};
        vecs[8]  = '{2'b00, 8'h02, 15'h3001, 32'h01234567, 17, 32'h0,        1, 0, 16, 0,  1, 8'hE3};
        vecs[9]  = '{2'b10, 8'h01, 15'h0100, 32'h0,        2,  32'h55555555, 1, 0, 0,  0,  1, 8'hE1};
        vecs[10] = '{2'b00, 8'h01, 15'h0200, 32'h0,        5,  32'h600DF00D, 2, 1, 0,  5,  2, 8'hA0};

        reset_n = 1'b0; i_valid = 1'b0; i_command = 8'h0; i_address = 15'h0; i_data = 32'h0;
        i_error = 2'b00; i_bus_rdata = 32'h0; i_bus_ack = 1'b0; i_tx_done = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset.bus", {o_bus_we, o_bus_re, o_tx_enable, o_tx_mode_select, o_busy}, 5'b0);
        check("reset.data", o_bus_addr | o_bus_wdata | o_tx_word | o_tx_byte | o_drop_count, 32'h0);
        reset_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_frame(vecs[i].err, vecs[i].cmd, vecs[i].addr, vecs[i].data, vecs[i].ack_lat,
                      vecs[i].rdata, vecs[i].tx_lat, vecs[i].extra);
            verify($sformatf("vec%0d", i), vecs[i].exp_we, vecs[i].exp_re, vecs[i].exp_nresp,
                   vecs[i].exp_status, vecs[i].rdata);
        end
        check("drop_once", 32'(o_drop_count), 32'd1);

        // Frame arriving alongside the final tx_done is dropped, not started
        run_frame(2'b00, 8'h03, 15'h0, 32'h0, 0, 32'h0, 2, 2);
        verify("done_edge", 0, 0, 1, 8'hA0, 32'h0);
        check("done_edge.cnt", 32'(o_drop_count), 32'd2);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0: cmd = 8'h01;
                1: cmd = 8'h02;
                2: cmd = 8'h03;
                3: cmd = 8'h01;
                default: cmd = 8'($urandom());
            endcase
            err = ($urandom_range(0, 6) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            lat = $urandom_range(0, TO + 2);
            rd  = $urandom();
            model(err, cmd, lat, we, re, nr, st);
            run_frame(err, cmd, 15'($urandom()), $urandom(), lat, rd, $urandom_range(1, 4),
                      $urandom_range(0, 3));
            verify($sformatf("rnd%0d", i), we, re, nr, st, rd);
        end

        // More than 255 busy frames saturate the counter
        run_frame(2'b00, 8'h03, 15'h0, 32'h0, 0, 32'h0, 300, 4);
        verify("saturate", 0, 0, 1, 8'hA0, 32'h0);
        check("saturate.cnt", 32'(o_drop_count), 32'hFF);
        run_frame(2'b00, 8'h01, 15'h0777, 32'h0, 4, 32'hA5A5A5A5, 1, 1);
        verify("saturate.hold", 0, 4, 2, 8'hA0, 32'hA5A5A5A5);

        // Reset in the middle of a bus read
        @(posedge clock); #1;
        i_valid = 1'b1; i_command = 8'h01; i_address = 15'h5555; i_error = 2'b00;
        @(posedge clock); #1;
        i_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_mid.pre_re", 32'(o_bus_re), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid.ctrl", {o_bus_we, o_bus_re, o_tx_enable, o_tx_mode_select, o_busy}, 5'b0);
        check("rst_mid.addr", 32'(o_bus_addr), 32'h0);
        check("rst_mid.data", o_bus_wdata | o_tx_word | o_tx_byte | o_drop_count, 32'h0);
        model_drops = 0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        en_hi = 0; busy_hi = 0;
        for (int i = 0; i < 20; i++) begin
            i_bus_ack = (i == 2);
            i_bus_rdata = 32'hFFFFFFFF;
            @(posedge clock); #1;
            if (o_tx_enable) en_hi++;
            if (o_busy) busy_hi++;
        end
        i_bus_ack = 1'b0;
        check("rst_mid.no_tx", en_hi, 0);
        check("rst_mid.idle", busy_hi, 0);
        run_frame(2'b00, 8'h03, 15'h0, 32'h0, 0, 32'h0, 1, 0);
        verify("post_rst_ping", 0, 0, 1, 8'hA0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
